bus_master_queue: RTL and testbench
===================================

# bus_master_queue

Per-master request queue placed directly upstream of the two-requester tristate bus: one instance feeds each `data_in_x`/`req_x` pair. It buffers words from a local producer in a small FIFO and raises a request while a word is pending. It pops the head word on each granted cycle, then inserts a one-cycle turnaround gap before requesting again, so a shared bus never sees back-to-back ownership without release. A saturating wait counter flags starvation when the other, higher-priority master holds the bus too long.

## Interface
- `N`, 8, data word width
- `DEPTH`, 4, FIFO depth in words; power of two, ≥2
- `STARVE_LIMIT`, 15, consecutive ungranted request cycles that set `starved`; ≥1
- `clk` input 1, single clock, rising edge
- `rst` input 1, reset; asynchronous, active-low (0 = reset)
- `wr_en` input 1, producer push strobe
- `wr_data` input N, word to push
- `full` output 1, FIFO holds DEPTH words
- `empty` output 1, FIFO holds 0 words
- `level` output $clog2(DEPTH)+1, current word count
- `overflow` output 1, one-cycle pulse: push was dropped
- `gnt` input 1, grant for this master from the bus arbiter
- `req` output 1, bus request (to `req_x`)
- `data_out` output N, head word (to `data_in_x`)
- `starved` output 1, wait counter saturated

## Operation
- FIFO: circular buffer, `wr_ptr`/`rd_ptr` of $clog2(DEPTH) bits wrap modulo DEPTH; `level` 0..DEPTH; `full`/`empty` decoded from `level`.
- Push accepted at an edge when `wr_en`=1 and (`level`<DEPTH or a pop occurs at the same edge). Otherwise the word is dropped and `overflow`=1 for the following cycle.
- Pop occurs at an edge when state=REQ and `gnt`=1. At most one push and one pop per edge; simultaneous push+pop leaves `level` unchanged.
- FSM states:
  - IDLE: `req`=0. Go to REQ when `level`≠0 (pre-edge value); else stay.
  - REQ: `req`=1, `data_out`=mem[`rd_ptr`]. `gnt`=1 → pop, go to GAP. `gnt`=0 → stay.
  - GAP: `req`=0, one cycle only. Go to REQ if `level`≠0 (pre-edge value), else IDLE.
- `data_out`=0 whenever `req`=0. It is stable throughout REQ, because pushes never alter the head.
- Wait counter:
  - Width $clog2(STARVE_LIMIT+1).
  - Increments at each edge in REQ with `gnt`=0, saturating at STARVE_LIMIT.
  - Clears on pop and whenever state≠REQ.
  - `starved`=(counter==STARVE_LIMIT). Informational only; it does not change request behaviour.
- `gnt` while not in REQ is ignored: no pop, no state change.

## Timing
- Reset (asynchronous assert, synchronous-safe deassert):
  - state=IDLE, pointers=0, `level`=0.
  - `empty`=1, `full`=0, `req`=0, `data_out`=0, `overflow`=0, `starved`=0, counter=0.
  - Queued words are discarded.
  - Reset mid-REQ drops `req` and `data_out` immediately (combinational from state).
- Latency from a push into an empty idle queue: push at edge k → `level`=1 after k → `req`=1 after edge k+1.
- Granted transfer: the word is taken at the edge where `req`=`gnt`=1. `req` is 0 for exactly one cycle afterwards. The next word is requested from the following edge.
- Sustained throughput: one word per 2 cycles while continuously granted.
- `overflow` is registered: it is high for exactly the cycle after the dropped-push edge.
- Full with simultaneous push+pop: push accepted, `level` stays DEPTH, no `overflow`.

## Test plan
- Reset: hold `rst`=0 with `wr_en`=1 → all outputs at reset values, `level`=0. Release → first push of 8'hAA gives `req`=1 and `data_out`=AA one cycle after `level`=1.
- Continuous grant: push AA, E5, 61 on consecutive edges, `gnt`=1 throughout → words taken in order AA, E5, 61 at alternating edges, with one `req`=0 gap between each. Ends in IDLE with `empty`=1.
- Overflow (DEPTH=4, `gnt`=0): push 5 words → `full`=1, `level`=4, the 5th is dropped, one-cycle `overflow` pulse. Next grant pops word 1, not word 5.
- Full + simultaneous push/pop: `level`=4, `gnt`=1 in REQ, `wr_en`=1 with CC → `level` stays 4, no `overflow`, CC is later delivered last.
- Starvation: one word queued, `gnt`=0 → `starved` rises after 15 REQ edges and holds. Then `gnt`=1 → pop, `starved`=0 next cycle, counter=0.
- Reset mid-operation: 3 words queued, in REQ → assert `rst` between edges → `req`, `data_out` and `level` drop to 0 immediately. Nothing is delivered after release until a new push.

Source files
------------

// File: rtl/bus_master_queue_if.sv
// ---------------------------------------------------------------------------
// bus_master_queue_if
// Bus-side signals between one master's request queue and the arbitrated
// tristate bus.
//   req      : bus request from the queue (to req_x)
//   gnt      : grant from the bus arbiter for this master
//   data_out : head word offered to the bus (to data_in_x), 0 when req=0
//   starved  : queue has waited STARVE_LIMIT ungranted cycles
// Modports:
//   master : the queue side (drives req/data_out/starved, samples gnt)
//   slave  : the arbiter/bus side
// ---------------------------------------------------------------------------
interface bus_master_queue_if #(
   parameter int N = 8
);
   logic         req;
   logic         gnt;
   logic [N-1:0] data_out;
   logic         starved;

   modport master (output req, output data_out, output starved, input gnt);
   modport slave  (input req, input data_out, input starved, output gnt);
endinterface

// File: rtl/bus_master_queue.sv
// ---------------------------------------------------------------------------
// bus_master_queue
// Per-master request queue feeding one requester port of the shared bus.
// Words from a local producer are held in a small circular FIFO; a request
// is raised while a word is pending, the head word is popped on each granted
// cycle, and a one-cycle turnaround gap follows every transfer so the bus
// never sees back-to-back ownership without release. A saturating wait
// counter flags starvation while the request sits ungranted.
// Ports:
//   clk      : clock, rising edge
//   rst      : asynchronous active-low reset
//   wr_en    : producer push strobe
//   wr_data  : word to push
//   full     : FIFO holds DEPTH words
//   empty    : FIFO holds no words
//   level    : current word count, 0..DEPTH
//   overflow : registered pulse, the push at the previous edge was dropped
//   bus      : req / gnt / data_out / starved (master modport)
// ---------------------------------------------------------------------------
module bus_master_queue #(
   parameter int N            = 8,
   parameter int DEPTH        = 4,
   parameter int STARVE_LIMIT = 15
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   wr_en,
   input  logic [N-1:0]           wr_data,
   output logic                   full,
   output logic                   empty,
   output logic [$clog2(DEPTH):0] level,
   output logic                   overflow,
   bus_master_queue_if.master     bus
);
   localparam int PW = $clog2(DEPTH);
   localparam int LW = PW + 1;
   localparam int CW = $clog2(STARVE_LIMIT + 1);
   localparam logic [LW-1:0] LEVEL_MAX = LW'(DEPTH);
   localparam logic [CW-1:0] WAIT_MAX  = CW'(STARVE_LIMIT);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      REQ  = 2'd1,
      GAP  = 2'd2
   } state_t;

   state_t          state, state_nxt;
   logic [N-1:0]    mem [DEPTH];
   logic [PW-1:0]   wr_ptr, rd_ptr;
   logic [CW-1:0]   wait_cnt;
   logic            push, pop;

   // A pop frees a slot at the same edge, so a full queue still accepts a push.
   assign pop  = (state == REQ) && bus.gnt;
   assign push = wr_en && ((level != LEVEL_MAX) || pop);

   assign full  = (level == LEVEL_MAX);
   assign empty = (level == '0);

   // Outputs decode straight from state so an asynchronous reset drops them
   // immediately; pushes only write behind the head, so data_out is stable
   // for the whole REQ period.
   assign bus.req      = (state == REQ);
   assign bus.data_out = (state == REQ) ? mem[rd_ptr] : '0;
   assign bus.starved  = (wait_cnt == WAIT_MAX);

   // NOTE: the storage array has no reset; stale contents are never visible
   // because data_out is gated by state and level tracks what is valid.
   always_ff @(posedge clk) begin
      if (push) mem[wr_ptr] <= wr_data;
   end

   // NOTE: all sequential state uses non-blocking assignments so every
   // register samples pre-edge values, regardless of block ordering.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state    <= IDLE;
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         level    <= '0;
         overflow <= 1'b0;
         wait_cnt <= '0;
      end else begin
         state    <= state_nxt;
         overflow <= wr_en && !push;
         if (push) wr_ptr <= wr_ptr + PW'(1);
         if (pop)  rd_ptr <= rd_ptr + PW'(1);
         if (push && !pop)      level <= level + LW'(1);
         else if (pop && !push) level <= level - LW'(1);
         // Counts ungranted request edges; any pop or non-REQ state clears it.
         if ((state == REQ) && !bus.gnt) begin
            if (wait_cnt != WAIT_MAX) wait_cnt <= wait_cnt + CW'(1);
         end else begin
            wait_cnt <= '0;
         end
      end
   end

   // NOTE: state_nxt gets a default before the case so no path leaves it
   // unassigned, which would otherwise infer a latch.
   always_comb begin
      state_nxt = state;
      unique case (state)
         IDLE: if (level != '0) state_nxt = REQ;
         REQ:  if (bus.gnt)     state_nxt = GAP;
         GAP:  state_nxt = (level != '0) ? REQ : IDLE;
         default: state_nxt = IDLE;
      endcase
   end
endmodule

// File: tb/tb_bus_master_queue.sv
// ---------------------------------------------------------------------------
// tb_bus_master_queue
// Directed, table-driven bench for bus_master_queue (N=8, DEPTH=4,
// STARVE_LIMIT=15). Each vector row drives one edge and lists the outputs
// expected just after it; reset, starvation and mid-operation reset are
// hand-written sequences.
// ---------------------------------------------------------------------------
module tb_bus_master_queue;
   localparam int N = 8;
   localparam int DEPTH = 4;

   logic         clk = 1'b0;
   logic         rst = 1'b0;
   logic         wr_en = 1'b0;
   logic [N-1:0] wr_data = '0;
   logic         full, empty, overflow;
   logic [2:0]   level;

   int n_checks = 0;
   int n_errors = 0;

   bus_master_queue_if #(.N(N)) bus ();

   bus_master_queue #(.N(N), .DEPTH(DEPTH), .STARVE_LIMIT(15)) dut (
      .clk      (clk),
      .rst      (rst),
      .wr_en    (wr_en),
      .wr_data  (wr_data),
      .full     (full),
      .empty    (empty),
      .level    (level),
      .overflow (overflow),
      .bus      (bus)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic       wr;
      logic [7:0] din;
      logic       gnt;
      logic       req;
      logic [7:0] dout;
      logic [2:0] lvl;
      logic       ovf;
   } vec_t;

   vec_t vq[$];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Drive inputs, take one rising edge, settle 1 time unit past it.
   task automatic step(input logic w, input logic [7:0] d, input logic g);
      wr_en   = w;
      wr_data = d;
      bus.gnt = g;
      @(posedge clk);
      #1;
   endtask

   task automatic add(input logic w, input logic [7:0] d, input logic g,
                      input logic r, input logic [7:0] o, input logic [2:0] l,
                      input logic v);
      vec_t t;
      t.wr = w; t.din = d; t.gnt = g; t.req = r; t.dout = o; t.lvl = l; t.ovf = v;
      vq.push_back(t);
   endtask

   initial begin
      // wr gnt in | req dout level overflow after the edge
      add(1, 8'hAA, 1,  0, 8'h00, 3'd1, 0); // push into idle queue
      add(1, 8'hE5, 1,  1, 8'hAA, 3'd2, 0); // req one edge after level=1
      add(1, 8'h61, 1,  0, 8'h00, 3'd2, 0); // AA taken, push+pop
      add(0, 8'h00, 1,  1, 8'hE5, 3'd2, 0);
      add(0, 8'h00, 1,  0, 8'h00, 3'd1, 0); // E5 taken
      add(0, 8'h00, 1,  1, 8'h61, 3'd1, 0);
      add(0, 8'h00, 1,  0, 8'h00, 3'd0, 0); // 61 taken
      add(0, 8'h00, 1,  0, 8'h00, 3'd0, 0); // GAP -> IDLE
      add(0, 8'h00, 1,  0, 8'h00, 3'd0, 0); // grant while idle ignored
      add(1, 8'h01, 0,  0, 8'h00, 3'd1, 0);
      add(1, 8'h02, 0,  1, 8'h01, 3'd2, 0);
      add(1, 8'h03, 0,  1, 8'h01, 3'd3, 0);
      add(1, 8'h04, 0,  1, 8'h01, 3'd4, 0); // full
      add(1, 8'h05, 0,  1, 8'h01, 3'd4, 1); // dropped -> overflow pulse
      add(0, 8'h00, 0,  1, 8'h01, 3'd4, 0); // pulse lasts one cycle
      add(1, 8'hCC, 1,  0, 8'h00, 3'd4, 0); // full push+pop, no overflow
      add(0, 8'h00, 0,  1, 8'h02, 3'd4, 0); // word 1 gone, head is 02
      add(0, 8'h00, 1,  0, 8'h00, 3'd3, 0);
      add(0, 8'h00, 0,  1, 8'h03, 3'd3, 0);
      add(0, 8'h00, 1,  0, 8'h00, 3'd2, 0);
      add(0, 8'h00, 1,  1, 8'h04, 3'd2, 0); // gnt during GAP ignored
      add(0, 8'h00, 1,  0, 8'h00, 3'd1, 0);
      add(0, 8'h00, 1,  1, 8'hCC, 3'd1, 0); // CC delivered last
      add(0, 8'h00, 1,  0, 8'h00, 3'd0, 0);
      add(0, 8'h00, 0,  0, 8'h00, 3'd0, 0);

      // Reset held with push strobe active.
      bus.gnt = 1'b1;
      wr_en   = 1'b1;
      wr_data = 8'hAA;
      repeat (3) @(posedge clk);
      #1;
      check("rst_req",      32'(bus.req),      32'd0);
      check("rst_dout",     32'(bus.data_out), 32'h0);
      check("rst_level",    32'(level),        32'd0);
      check("rst_empty",    32'(empty),        32'd1);
      check("rst_full",     32'(full),         32'd0);
      check("rst_overflow", 32'(overflow),     32'd0);
      check("rst_starved",  32'(bus.starved),  32'd0);
      wr_en = 1'b0;
      #2 rst = 1'b1;

      foreach (vq[i]) begin
         step(vq[i].wr, vq[i].din, vq[i].gnt);
         check($sformatf("v%0d_req", i),      32'(bus.req),      32'(vq[i].req));
         check($sformatf("v%0d_dout", i),     32'(bus.data_out), 32'(vq[i].dout));
         check($sformatf("v%0d_level", i),    32'(level),        32'(vq[i].lvl));
         check($sformatf("v%0d_full", i),     32'(full),         32'(vq[i].lvl == 3'd4));
         check($sformatf("v%0d_empty", i),    32'(empty),        32'(vq[i].lvl == 3'd0));
         check($sformatf("v%0d_overflow", i), 32'(overflow),     32'(vq[i].ovf));
         check($sformatf("v%0d_starved", i),  32'(bus.starved),  32'd0);
      end

      // Starvation: one word waits ungranted.
      step(1, 8'h77, 0);
      step(0, 8'h00, 0);
      check("stv_enter_req", 32'(bus.req), 32'd1);
      for (int i = 1; i <= 14; i++) begin
         step(0, 8'h00, 0);
         check($sformatf("stv_wait%0d", i), 32'(bus.starved), 32'd0);
      end
      step(0, 8'h00, 0);
      check("stv_set", 32'(bus.starved), 32'd1);
      for (int i = 0; i < 3; i++) begin
         step(0, 8'h00, 0);
         check($sformatf("stv_hold%0d", i), 32'(bus.starved), 32'd1);
         check($sformatf("stv_dout%0d", i), 32'(bus.data_out), 32'h77);
      end
      step(0, 8'h00, 1);
      check("stv_clear",     32'(bus.starved), 32'd0);
      check("stv_pop_req",   32'(bus.req),     32'd0);
      check("stv_pop_level", 32'(level),       32'd0);
      step(0, 8'h00, 0);
      check("stv_idle_req",  32'(bus.req),     32'd0);

      // Reset between edges while requesting with three words queued.
      step(1, 8'h10, 0);
      step(1, 8'h20, 0);
      step(1, 8'h30, 0);
      check("mid_pre_req",  32'(bus.req),      32'd1);
      check("mid_pre_dout", 32'(bus.data_out), 32'h10);
      wr_en = 1'b0;
      #2 rst = 1'b0;
      #1;
      check("mid_req",   32'(bus.req),      32'd0);
      check("mid_dout",  32'(bus.data_out), 32'h0);
      check("mid_level", 32'(level),        32'd0);
      check("mid_empty", 32'(empty),        32'd1);
      #2 rst = 1'b1;
      for (int i = 0; i < 3; i++) begin
         step(0, 8'h00, 1);
         check($sformatf("post_req%0d", i),   32'(bus.req), 32'd0);
         check($sformatf("post_level%0d", i), 32'(level),   32'd0);
      end
      step(1, 8'h5A, 0);
      step(0, 8'h00, 0);
      check("new_req",  32'(bus.req),      32'd1);
      check("new_dout", 32'(bus.data_out), 32'h5A);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end
endmodule
